hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32 core.
- Watches the decode-stage source registers, the ID_EX outputs (opcode, funct7, rd), the M-extension unit (MDU) handshake and the data-memory handshake.
- Drives stall, hold and flush strobes for the PC, IF_ID, ID_EX and EX_MEM registers.
- Sequences multi-cycle MDU operations and data-memory wait states through a small FSM, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/hazard_luse_det.sv | 34 +++
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode constants, FSM encodings and strobe bundle for the pipeline
// hazard controller and the helpers that reuse its decodes.
package hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MDU_WAIT = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mdu_start;
  } hz_strobe_t;

  function automatic logic is_load_op(input logic [6:0] opcode);
    return opcode == OPC_LOAD;
  endfunction

  function automatic logic is_mdu_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/hazard_luse_det.sv
// Combinational load-use comparator: flags a decode-stage source that
// matches the destination of a load currently sitting in EX.
module hazard_luse_det
  import hazard_ctrl_pkg::*;
(
  input  logic                 ex_load,
  input  logic                 ex_rd_we,
  input  logic [REG_IDX_W-1:0] ex_rd_addr,
  input  logic                 id_rs1_re,
  input  logic [REG_IDX_W-1:0] id_rs1_addr,
  input  logic                 id_rs2_re,
  input  logic [REG_IDX_W-1:0] id_rs2_addr,
  output logic                 luse
);

  logic [1:0]           src_re;
  logic [REG_IDX_W-1:0] src_addr [2];
  logic [1:0]           src_hit;

  assign src_re      = {id_rs2_re, id_rs1_re};
  assign src_addr[0] = id_rs1_addr;
  assign src_addr[1] = id_rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_re[gi] && (src_addr[gi] == ex_rd_addr);
    end
  endgenerate

  // x0 is never a real dependency, so a load into x0 cannot stall decode.
  assign luse = ex_load && ex_rd_we && (ex_rd_addr != '0) && (|src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush strobes for load-use, branch
// redirect, multi-cycle MDU operations and data-memory wait states.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int TO_WIDTH    = 7,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_rs1_re,
  input  logic [REG_IDX_W-1:0] id_rs1_addr,
  input  logic                 id_rs2_re,
  input  logic [REG_IDX_W-1:0] id_rs2_addr,
  input  logic [6:0]           ex_opcode,
  input  logic [6:0]           ex_funct7,
  input  logic                 ex_rd_we,
  input  logic [REG_IDX_W-1:0] ex_rd_addr,
  input  logic                 ex_redirect,
  input  logic                 mdu_done,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic                 ex_mem_flush,
  output logic                 mdu_start,
  output logic                 mdu_err,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [TO_WIDTH-1:0]  TO_LAST = TO_WIDTH'(MDU_TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0]  TO_ONE  = TO_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  hz_state_e            state_reg, state_next;
  logic [TO_WIDTH-1:0]  to_cnt_reg, to_cnt_next;
  logic                 mdu_err_reg, mdu_err_next;
  logic [CNT_WIDTH-1:0] stall_cnt_reg, stall_cnt_next;
  hz_strobe_t           strb_fsm, strb;
  logic                 ex_load, ex_mdu, luse, mem_block;

  assign ex_load   = is_load_op(ex_opcode);
  assign ex_mdu    = is_mdu_op(ex_opcode, ex_funct7);
  assign mem_block = mem_req && !mem_ready;

  hazard_luse_det u_luse_det (
    .ex_load     (ex_load),
    .ex_rd_we    (ex_rd_we),
    .ex_rd_addr  (ex_rd_addr),
    .id_rs1_re   (id_rs1_re),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_re   (id_rs2_re),
    .id_rs2_addr (id_rs2_addr),
    .luse        (luse)
  );

  always_comb begin
    strb_fsm     = '0;
    state_next   = state_reg;
    to_cnt_next  = to_cnt_reg;
    mdu_err_next = mdu_err_reg;
    case (state_reg)
      HZ_RUN: begin
        if (mem_block) begin
          strb_fsm.pc_stall     = 1'b1;
          strb_fsm.if_id_stall  = 1'b1;
          strb_fsm.id_ex_stall  = 1'b1;
          strb_fsm.ex_mem_stall = 1'b1;
          state_next            = HZ_MEM_WAIT;
        end else if (ex_mdu) begin
          strb_fsm.mdu_start    = 1'b1;
          strb_fsm.pc_stall     = 1'b1;
          strb_fsm.if_id_stall  = 1'b1;
          strb_fsm.id_ex_stall  = 1'b1;
          strb_fsm.ex_mem_flush = 1'b1;
          state_next            = HZ_MDU_WAIT;
          to_cnt_next           = '0;
        end else if (ex_redirect) begin
          // The younger instruction is killed, so any load-use on it is moot.
          strb_fsm.if_id_flush = 1'b1;
          strb_fsm.id_ex_flush = 1'b1;
        end else if (luse) begin
          strb_fsm.pc_stall    = 1'b1;
          strb_fsm.if_id_stall = 1'b1;
          strb_fsm.id_ex_flush = 1'b1;
        end
      end
      HZ_MDU_WAIT: begin
        if (mdu_done) begin
          state_next = HZ_RUN;
        end else if (to_cnt_reg == TO_LAST) begin
          // Give up and let the instruction retire with whatever the MDU shows.
          mdu_err_next = 1'b1;
          state_next   = HZ_RUN;
        end else begin
          strb_fsm.pc_stall     = 1'b1;
          strb_fsm.if_id_stall  = 1'b1;
          strb_fsm.id_ex_stall  = 1'b1;
          strb_fsm.ex_mem_flush = 1'b1;
          to_cnt_next           = to_cnt_reg + TO_ONE;
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_ready) begin
          state_next = HZ_RUN;
        end else begin
          strb_fsm.pc_stall     = 1'b1;
          strb_fsm.if_id_stall  = 1'b1;
          strb_fsm.id_ex_stall  = 1'b1;
          strb_fsm.ex_mem_stall = 1'b1;
        end
      end
      default: state_next = HZ_RUN;
    endcase
  end

  // Strobes are forced quiet while reset is held, independent of the clock.
  assign strb = rst ? strb_fsm : '0;

  assign stall_cnt_next = (strb.pc_stall && (stall_cnt_reg != '1))
                          ? stall_cnt_reg + CNT_ONE : stall_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= HZ_RUN;
      to_cnt_reg    <= '0;
      mdu_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      to_cnt_reg    <= to_cnt_next;
      mdu_err_reg   <= mdu_err_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign pc_stall     = strb.pc_stall;
  assign if_id_stall  = strb.if_id_stall;
  assign if_id_flush  = strb.if_id_flush;
  assign id_ex_stall  = strb.id_ex_stall;
  assign id_ex_flush  = strb.id_ex_flush;
  assign ex_mem_stall = strb.ex_mem_stall;
  assign ex_mem_flush = strb.ex_mem_flush;
  assign mdu_start    = strb.mdu_start;
  assign mdu_err      = mdu_err_reg;
  assign state        = state_reg;
  assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized transaction-level bench for hazard_ctrl with a scoreboard queue
// filled by the stimulus side and drained by an independent monitor.
module tb_hazard_ctrl;

  localparam int TO = 8;
  localparam int CW = 8;
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [6:0] OPC_LOAD_T = 7'b0000011;
  localparam logic [6:0] OPC_OP_T   = 7'b0110011;
  localparam logic [6:0] OPC_IMM_T  = 7'b0010011;
  localparam logic [6:0] F7_MD_T    = 7'b0000001;

  // Strobe order: pc_stall if_id_stall if_id_flush id_ex_stall id_ex_flush ex_mem_stall ex_mem_flush mdu_start
  localparam logic [7:0] S_NONE      = 8'h00;
  localparam logic [7:0] S_FREEZE    = 8'hD4;
  localparam logic [7:0] S_MDU_START = 8'hD3;
  localparam logic [7:0] S_MDU_HOLD  = 8'hD2;
  localparam logic [7:0] S_REDIR     = 8'h28;
  localparam logic [7:0] S_BUBBLE    = 8'hC8;

  typedef struct packed {
    logic       rs1_re;
    logic [4:0] rs1;
    logic       rs2_re;
    logic [4:0] rs2;
    logic [6:0] opc;
    logic [6:0] f7;
    logic       rd_we;
    logic [4:0] rd;
    logic       redirect;
    logic       done;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct {
    int            txn;
    logic [7:0]    strb;
    logic [1:0]    st;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk, rst;
  logic          id_rs1_re, id_rs2_re, ex_rd_we, ex_redirect, mdu_done, mem_req, mem_ready;
  logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic [6:0]    ex_opcode, ex_funct7;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_stall, ex_mem_flush, mdu_start, mdu_err;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;

  int            checks = 0;
  int            errors = 0;
  int            txn_id = 0;
  logic          m_err;
  logic [CW-1:0] m_cnt;
  exp_t          sb_q[$];

  hazard_ctrl #(.MDU_TIMEOUT(TO), .TO_WIDTH(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_re(id_rs1_re), .id_rs1_addr(id_rs1_addr),
    .id_rs2_re(id_rs2_re), .id_rs2_addr(id_rs2_addr),
    .ex_opcode(ex_opcode), .ex_funct7(ex_funct7),
    .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .mdu_done(mdu_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mdu_start(mdu_start), .mdu_err(mdu_err), .state(state), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endfunction

  function automatic logic [7:0] act_strb();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
            id_ex_flush, ex_mem_stall, ex_mem_flush, mdu_start};
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'd31;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1_re = 1'($urandom_range(0, 1));
    s.rs1    = pick_reg();
    s.rs2_re = 1'($urandom_range(0, 1));
    s.rs2    = pick_reg();
    case ($urandom_range(0, 3))
      0, 1:    s.opc = OPC_LOAD_T;
      2:       s.opc = OPC_OP_T;
      default: s.opc = OPC_IMM_T;
    endcase
    s.f7       = ($urandom_range(0, 2) == 0) ? F7_MD_T : 7'($urandom);
    s.rd_we    = ($urandom_range(0, 3) != 0);
    s.rd       = pick_reg();
    s.redirect = ($urandom_range(0, 3) == 0);
    s.done     = ($urandom_range(0, 3) == 0);
    s.mreq     = 1'($urandom_range(0, 1));
    s.mrdy     = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic logic is_luse(stim_t s);
    return (s.opc == OPC_LOAD_T) && s.rd_we && (s.rd != 5'd0) &&
           ((s.rs1_re && s.rs1 == s.rd) || (s.rs2_re && s.rs2 == s.rd));
  endfunction

  task automatic drive(input stim_t s);
    id_rs1_re   = s.rs1_re;   id_rs1_addr = s.rs1;
    id_rs2_re   = s.rs2_re;   id_rs2_addr = s.rs2;
    ex_opcode   = s.opc;      ex_funct7   = s.f7;
    ex_rd_we    = s.rd_we;    ex_rd_addr  = s.rd;
    ex_redirect = s.redirect; mdu_done    = s.done;
    mem_req     = s.mreq;     mem_ready   = s.mrdy;
  endtask

  // One clock of stimulus plus the response the reference expects for it.
  task automatic issue(input stim_t s, input logic [7:0] strb, input logic [1:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    drive(s);
    e.txn = txn_id; e.strb = strb; e.st = st; e.err = m_err; e.cnt = m_cnt;
    sb_q.push_back(e);
    if (strb[7] && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic txn_plain(input stim_t s);
    logic [7:0] strb;
    if (s.opc == OPC_OP_T && s.f7 == F7_MD_T) s.f7 = 7'h20;
    if (s.mreq) s.mrdy = 1'b1;
    if (s.redirect)     strb = S_REDIR;
    else if (is_luse(s)) strb = S_BUBBLE;
    else                strb = S_NONE;
    issue(s, strb, 2'd0);
    $display("txn %0d plain redirect=%0b luse=%0b strobes=%02h", txn_id, s.redirect, is_luse(s), strb);
    txn_id++;
  endtask

  // MDU answers d cycles after launch; beyond TO cycles it never answers in time.
  task automatic txn_mdu(input int d, input stim_t s0);
    int    n_wait;
    stim_t s;
    n_wait = (d <= TO) ? d : TO;
    s0.opc = OPC_OP_T; s0.f7 = F7_MD_T;
    if (s0.mreq) s0.mrdy = 1'b1;
    issue(s0, S_MDU_START, 2'd0);
    for (int k = 0; k < n_wait; k++) begin
      s = rand_stim();
      s.opc = s0.opc; s.f7 = s0.f7; s.rd_we = s0.rd_we; s.rd = s0.rd;
      s.done = (k == d - 1);
      issue(s, (k == n_wait - 1) ? S_NONE : S_MDU_HOLD, 2'd1);
    end
    if (d > TO) m_err = 1'b1;
    $display("txn %0d mdu done_after=%0d stall_cycles=%0d timeout=%0b", txn_id, d, n_wait, d > TO);
    txn_id++;
  endtask

  task automatic txn_mem(input int w, input stim_t s0, input logic force_redir);
    stim_t s;
    s0.mreq = 1'b1; s0.mrdy = 1'b0;
    issue(s0, S_FREEZE, 2'd0);
    for (int k = 0; k < w; k++) begin
      s = rand_stim();
      s.mreq = 1'b1;
      s.mrdy = (k == w - 1);
      if (force_redir) s.redirect = 1'b1;
      issue(s, (k == w - 1) ? S_NONE : S_FREEZE, 2'd2);
    end
    $display("txn %0d mem wait_cycles=%0d", txn_id, w);
    txn_id++;
  endtask

  task automatic check_now(string name, logic [7:0] strb, logic [1:0] st, logic err, logic [CW-1:0] cnt);
    check({name, ".strobes"}, 32'(act_strb()), 32'(strb));
    check({name, ".state"}, 32'(state), 32'(st));
    check({name, ".mdu_err"}, 32'(mdu_err), 32'(err));
    check({name, ".stall_cnt"}, 32'(stall_cnt), 32'(cnt));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check($sformatf("txn%0d.strobes", e.txn), 32'(act_strb()), 32'(e.strb));
        check($sformatf("txn%0d.state", e.txn), 32'(state), 32'(e.st));
        check($sformatf("txn%0d.mdu_err", e.txn), 32'(mdu_err), 32'(e.err));
        check($sformatf("txn%0d.stall_cnt", e.txn), 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    stim_t s, base;
    int    kind;
    m_err = 1'b0;
    m_cnt = '0;
    rst   = 1'b0;
    s = rand_stim();
    s.opc = OPC_OP_T; s.f7 = F7_MD_T; s.mreq = 1'b1; s.mrdy = 1'b0; s.redirect = 1'b1;
    drive(s);
    #3;
    check_now("reset_hold", S_NONE, 2'd0, 1'b0, '0);
    @(negedge clk);
    check_now("reset_after_edge", S_NONE, 2'd0, 1'b0, '0);
    drive('0);
    rst = 1'b1;
    $display("txn %0d reset released", txn_id);
    txn_id++;

    // Load-use hits and near misses.
    base = '0;
    base.opc = OPC_LOAD_T; base.rd_we = 1'b1; base.rd = 5'd5; base.rs2_re = 1'b1; base.rs2 = 5'd5;
    txn_plain(base);
    txn_plain('0);
    s = base; s.rd = 5'd0; s.rs2 = 5'd0; txn_plain(s);
    s = base; s.rs2_re = 1'b0; s.rs1_re = 1'b1; s.rs1 = 5'd5; txn_plain(s);
    s = base; s.rs2_re = 1'b0; txn_plain(s);
    s = base; s.rd_we = 1'b0; txn_plain(s);
    s = base; s.redirect = 1'b1; txn_plain(s);

    // MDU sequencing, including done on the first and on the last allowed cycle.
    txn_mdu(4, '0);
    txn_plain('0);
    txn_mdu(1, '0);
    txn_mdu(TO, '0);

    // Memory wait with a redirect that must only act after release.
    txn_mem(3, '0, 1'b1);
    s = '0; s.redirect = 1'b1; txn_plain(s);
    txn_mem(1, base, 1'b0);

    // MDU timeout and sticky error.
    txn_mdu(TO + 1, '0);
    txn_plain('0);
    txn_plain(base);

    // Asynchronous reset in the second MDU wait cycle.
    s = '0; s.opc = OPC_OP_T; s.f7 = F7_MD_T;
    issue(s, S_MDU_START, 2'd0);
    issue(s, S_MDU_HOLD, 2'd1);
    @(posedge clk);
    #1;
    drive(s);
    #1;
    check("mid_mdu.strobes", 32'(act_strb()), 32'(S_MDU_HOLD));
    check("mid_mdu.state", 32'(state), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_now("async_reset", S_NONE, 2'd0, 1'b0, '0);
    m_err = 1'b0;
    m_cnt = '0;
    s.mreq = 1'b1; s.redirect = 1'b1;
    drive(s);
    @(negedge clk);
    check_now("async_reset_held", S_NONE, 2'd0, 1'b0, '0);
    drive('0);
    rst = 1'b1;
    $display("txn %0d async reset during mdu wait", txn_id);
    txn_id++;
    txn_mdu(TO, '0);
    txn_plain('0);

    // Randomized traffic; long enough to drive stall_cnt into saturation.
    for (int t = 0; t < 400; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4)      txn_plain(rand_stim());
      else if (kind < 7) txn_mdu($urandom_range(1, TO + 3), rand_stim());
      else               txn_mem($urandom_range(1, 5), rand_stim(), 1'b0);
    end
    txn_plain('0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
